// File: rtl/ooo_pkg.sv
// Shared defaults and types for the out-of-order rename stage.
package ooo_pkg;

  localparam int NUM_LREG_DEF = 32;
  localparam int NUM_PREG_DEF = 64;
  localparam int DW_DEF       = 2;
  localparam int NUM_CKPT_DEF = 4;

  // Wide enough to rank any practical number of in-flight checkpoints.
  localparam int CKPT_AGE_W = 8;
  typedef logic [CKPT_AGE_W-1:0] ckpt_age_t;

endpackage

// File: rtl/map_ckpt_store.sv
// Branch checkpoint storage: holds map snapshots, allocates the lowest free
// slot, and frees by age (a mispredict frees its checkpoint and all younger).
// Age 0 is the youngest busy checkpoint; ages are re-ranked every edge.
module map_ckpt_store
  import ooo_pkg::*;
#(
  parameter int NUM_LREG = NUM_LREG_DEF,
  parameter int PW       = 6,
  parameter int NUM_CKPT = NUM_CKPT_DEF,
  localparam int CW      = $clog2(NUM_CKPT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_en,
  input  logic [NUM_LREG-1:0][PW-1:0]   alloc_map,
  input  logic                          free_en,
  input  logic [CW-1:0]                 free_id,
  input  logic                          restore_en,
  input  logic [CW-1:0]                 restore_id,
  output logic [NUM_LREG-1:0][PW-1:0]   restore_map,
  output logic                          ckpt_full,
  output logic [CW-1:0]                 alloc_id
);

  logic [NUM_CKPT-1:0]                       busy_q, busy_d;
  ckpt_age_t [NUM_CKPT-1:0]                  age_q, age_d;
  logic [NUM_CKPT-1:0][NUM_LREG-1:0][PW-1:0] snap_q, snap_d;
  logic [NUM_CKPT-1:0]                       freed, survive;
  ckpt_age_t                                 rank;
  logic                                      do_alloc;

  assign ckpt_full   = &busy_q;
  assign restore_map = snap_q[restore_id];

  // Pick the lowest-numbered free checkpoint.
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_CKPT - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_id = CW'(i);
    end
  end

  // Free resolved/squashed checkpoints, re-rank survivors by age, then allocate.
  always_comb begin
    busy_d   = busy_q;
    age_d    = age_q;
    snap_d   = snap_q;
    freed    = '0;
    survive  = '0;
    rank     = '0;
    do_alloc = alloc_en && !ckpt_full;
    if (restore_en) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (busy_q[i] && (age_q[i] <= age_q[restore_id])) freed[i] = 1'b1;
      end
    end
    if (free_en) freed[free_id] = 1'b1;
    survive = busy_q & ~freed;
    for (int i = 0; i < NUM_CKPT; i++) begin
      rank = do_alloc ? ckpt_age_t'(1) : ckpt_age_t'(0);
      for (int j = 0; j < NUM_CKPT; j++) begin
        if (survive[j] && (age_q[j] < age_q[i])) rank = rank + ckpt_age_t'(1);
      end
      age_d[i] = survive[i] ? rank : ckpt_age_t'(0);
    end
    busy_d = survive;
    if (do_alloc) begin
      busy_d[alloc_id] = 1'b1;
      age_d[alloc_id]  = '0;
      snap_d[alloc_id] = alloc_map;
    end
  end

  // Checkpoint state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      age_q  <= '0;
      snap_q <= '0;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
      snap_q <= snap_d;
    end
  end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register rename map with branch checkpoints, ROB-walk recovery and a
// physical-register ready table. Optional macro MAPT_READY_BYPASS_EN makes a
// same-cycle completion visible on the source-ready outputs.
module rename_map_ckpt
  import ooo_pkg::*;
#(
  parameter int NUM_LREG = NUM_LREG_DEF,
  parameter int NUM_PREG = NUM_PREG_DEF,
  parameter int DW       = DW_DEF,
  parameter int NUM_CKPT = NUM_CKPT_DEF,
  localparam int LW      = $clog2(NUM_LREG),
  localparam int PW      = $clog2(NUM_PREG),
  localparam int CW      = $clog2(NUM_CKPT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic [DW-1:0]    disp_valid,
  input  logic [DW*LW-1:0] l_rs,
  input  logic [DW*LW-1:0] l_rt,
  input  logic [DW*LW-1:0] l_rd,
  input  logic [DW-1:0]    reg_dest,
  input  logic [DW*PW-1:0] p_rd_new,
  input  logic [DW-1:0]    is_branch,
  output logic [DW*PW-1:0] p_rs,
  output logic [DW*PW-1:0] p_rt,
  output logic [DW-1:0]    p_rs_v,
  output logic [DW-1:0]    p_rt_v,
  output logic [DW*PW-1:0] pr_old_rd,
  output logic             ckpt_full,
  output logic [CW-1:0]    ckpt_id,
  input  logic             br_resolve,
  input  logic             br_mispredict,
  input  logic [CW-1:0]    br_ckpt_id,
  input  logic             recover,
  input  logic [LW-1:0]    recover_rd,
  input  logic [PW-1:0]    p_rd_flush,
  input  logic             regdest_rob,
  input  logic             complete,
  input  logic [PW-1:0]    p_rd_compl,
  input  logic             regdest_compl
);

  logic [NUM_LREG-1:0][PW-1:0] map_q, map_d, work_map, snap_map, restore_map;
  logic [NUM_PREG-1:0]         ready_q, ready_d;
  logic restore_en, free_en, branch_in_group, disp_ok, alloc_en;
  logic [PW-1:0] ps, pt, po;
  logic          psv, ptv;

  // A branch group that finds no free checkpoint is held back as a whole.
  assign restore_en      = br_resolve & br_mispredict;
  assign free_en         = br_resolve & ~br_mispredict;
  assign branch_in_group = |(disp_valid & is_branch);
  assign disp_ok         = ~hazard_stall & ~recover & ~restore_en & ~(branch_in_group & ckpt_full);
  assign alloc_en        = disp_ok & branch_in_group;

  map_ckpt_store #(
    .NUM_LREG (NUM_LREG),
    .PW       (PW),
    .NUM_CKPT (NUM_CKPT)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_map   (snap_map),
    .free_en     (free_en),
    .free_id     (br_ckpt_id),
    .restore_en  (restore_en),
    .restore_id  (br_ckpt_id),
    .restore_map (restore_map),
    .ckpt_full   (ckpt_full),
    .alloc_id    (ckpt_id)
  );

  // Source and old-destination lookup with youngest-earlier-slot bypass.
  always_comb begin
    p_rs      = '0;
    p_rt      = '0;
    p_rs_v    = '0;
    p_rt_v    = '0;
    pr_old_rd = '0;
    ps = '0; pt = '0; po = '0; psv = 1'b0; ptv = 1'b0;
    for (int k = 0; k < DW; k++) begin
      ps  = map_q[l_rs[k*LW +: LW]];
      pt  = map_q[l_rt[k*LW +: LW]];
      po  = map_q[l_rd[k*LW +: LW]];
      psv = ready_q[ps];
      ptv = ready_q[pt];
      for (int j = 0; j < k; j++) begin
        if (disp_valid[j] && reg_dest[j]) begin
          if (l_rd[j*LW +: LW] == l_rs[k*LW +: LW]) begin
            ps  = p_rd_new[j*PW +: PW];
            psv = 1'b0;
          end
          if (l_rd[j*LW +: LW] == l_rt[k*LW +: LW]) begin
            pt  = p_rd_new[j*PW +: PW];
            ptv = 1'b0;
          end
          if (l_rd[j*LW +: LW] == l_rd[k*LW +: LW]) po = p_rd_new[j*PW +: PW];
        end
      end
`ifdef MAPT_READY_BYPASS_EN
      if (complete && regdest_compl && (ps == p_rd_compl)) psv = 1'b1;
      if (complete && regdest_compl && (pt == p_rd_compl)) ptv = 1'b1;
`endif
      p_rs[k*PW +: PW]      = ps;
      p_rt[k*PW +: PW]      = pt;
      pr_old_rd[k*PW +: PW] = po;
      p_rs_v[k]             = psv;
      p_rt_v[k]             = ptv;
    end
  end

  // Next map/ready: restore beats recover beats dispatch; completion set wins.
  always_comb begin
    map_d    = map_q;
    ready_d  = ready_q;
    work_map = map_q;
    snap_map = map_q;
    for (int k = 0; k < DW; k++) begin
      if (disp_valid[k] && reg_dest[k]) work_map[l_rd[k*LW +: LW]] = p_rd_new[k*PW +: PW];
      if (disp_valid[k] && is_branch[k]) snap_map = work_map;
    end
    if (restore_en) begin
      map_d = restore_map;
    end else if (recover) begin
      if (regdest_rob) map_d[recover_rd] = p_rd_flush;
    end else if (disp_ok) begin
      map_d = work_map;
      for (int k = 0; k < DW; k++) begin
        if (disp_valid[k] && reg_dest[k]) ready_d[p_rd_new[k*PW +: PW]] = 1'b0;
      end
    end
    if (complete && regdest_compl) ready_d[p_rd_compl] = 1'b1;
  end

  // Map and ready registers; reset gives the identity map, all ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LREG; i++) map_q[i] <= PW'(i);
      ready_q <= '1;
    end else begin
      map_q   <= map_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed bench for rename_map_ckpt: lookup/bypass, WAW, ready tracking,
// checkpoint allocate/free/restore, recovery walk and reset abort.
module tb_rename_map_ckpt;

  localparam int DW = 2;
  localparam int LW = 5;
  localparam int PW = 6;
  localparam int CW = 2;
`ifdef MAPT_READY_BYPASS_EN
  localparam logic BYP_EXP = 1'b1;
`else
  localparam logic BYP_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             hazard_stall;
  logic [DW-1:0]    disp_valid, reg_dest, is_branch;
  logic [DW*LW-1:0] l_rs, l_rt, l_rd;
  logic [DW*PW-1:0] p_rd_new;
  logic [DW*PW-1:0] p_rs, p_rt, pr_old_rd;
  logic [DW-1:0]    p_rs_v, p_rt_v;
  logic             ckpt_full;
  logic [CW-1:0]    ckpt_id;
  logic             br_resolve, br_mispredict;
  logic [CW-1:0]    br_ckpt_id;
  logic             recover, regdest_rob;
  logic [LW-1:0]    recover_rd;
  logic [PW-1:0]    p_rd_flush, p_rd_compl;
  logic             complete, regdest_compl;

  int checks = 0;
  int errors = 0;

  rename_map_ckpt dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
    .disp_valid(disp_valid), .l_rs(l_rs), .l_rt(l_rt), .l_rd(l_rd),
    .reg_dest(reg_dest), .p_rd_new(p_rd_new), .is_branch(is_branch),
    .p_rs(p_rs), .p_rt(p_rt), .p_rs_v(p_rs_v), .p_rt_v(p_rt_v),
    .pr_old_rd(pr_old_rd), .ckpt_full(ckpt_full), .ckpt_id(ckpt_id),
    .br_resolve(br_resolve), .br_mispredict(br_mispredict), .br_ckpt_id(br_ckpt_id),
    .recover(recover), .recover_rd(recover_rd), .p_rd_flush(p_rd_flush),
    .regdest_rob(regdest_rob), .complete(complete), .p_rd_compl(p_rd_compl),
    .regdest_compl(regdest_compl)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    hazard_stall = 0; disp_valid = '0; reg_dest = '0; is_branch = '0;
    l_rs = '0; l_rt = '0; l_rd = '0; p_rd_new = '0;
    br_resolve = 0; br_mispredict = 0; br_ckpt_id = '0;
    recover = 0; recover_rd = '0; p_rd_flush = '0; regdest_rob = 0;
    complete = 0; p_rd_compl = '0; regdest_compl = 0;
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [LW-1:0] rs,
                               input logic [LW-1:0] rt, input logic [LW-1:0] rd,
                               input logic rdest, input logic [PW-1:0] prd, input logic br);
    disp_valid[k]       = v;
    l_rs[k*LW +: LW]    = rs;
    l_rt[k*LW +: LW]    = rt;
    l_rd[k*LW +: LW]    = rd;
    reg_dest[k]         = rdest;
    p_rd_new[k*PW +: PW] = prd;
    is_branch[k]        = br;
  endtask

  // Slot 0 never sees intra-group bypass, so it reads the map directly.
  task automatic checkMap(input string tag, input logic [LW-1:0] r, input logic [PW-1:0] exp);
    l_rs[0 +: LW] = r;
    #1;
    checkOutput(tag, p_rs[0 +: PW], exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    #2;
    checkMap("rst_map5", 5, 6'd5);
    checkOutput("rst_full", ckpt_full, 0);
    checkOutput("rst_ckpt_id", ckpt_id, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    l_rs[0 +: LW] = 5; l_rt[0 +: LW] = 31;
    #1;
    checkOutput("lookup_p_rs", p_rs[0 +: PW], 5);
    checkOutput("lookup_p_rs_v", p_rs_v[0], 1);
    checkOutput("lookup_p_rt", p_rt[0 +: PW], 31);

    clearInputs();
    applyStimulus(0, 1, 0, 0, 3, 1, 6'h20, 0);
    applyStimulus(1, 1, 3, 4, 8, 0, 6'h00, 0);
    #1;
    checkOutput("bypass_p_rs1", p_rs[PW +: PW], 6'h20);
    checkOutput("bypass_p_rs_v1", p_rs_v[1], 0);
    checkOutput("nobypass_p_rt1", p_rt[PW +: PW], 4);
    checkOutput("nobypass_p_rt_v1", p_rt_v[1], 1);
    checkOutput("old_rd0", pr_old_rd[0 +: PW], 3);
    step();
    clearInputs();
    checkMap("map3_after_disp", 3, 6'h20);
    checkOutput("ready20_cleared", p_rs_v[0], 0);

    applyStimulus(0, 1, 0, 0, 7, 1, 6'h21, 0);
    applyStimulus(1, 1, 0, 0, 7, 1, 6'h22, 0);
    #1;
    checkOutput("waw_old_rd0", pr_old_rd[0 +: PW], 7);
    checkOutput("waw_old_rd1", pr_old_rd[PW +: PW], 6'h21);
    step();
    clearInputs();
    checkMap("waw_map7", 7, 6'h22);

    l_rs[0 +: LW] = 3;
    complete = 1; p_rd_compl = 6'h20; regdest_compl = 0;
    #1;
    checkOutput("compl_nodest_now", p_rs_v[0], 0);
    step();
    checkOutput("compl_nodest_next", p_rs_v[0], 0);
    regdest_compl = 1;
    #1;
    checkOutput("compl_same_cycle", p_rs_v[0], BYP_EXP);
    step();
    complete = 0; regdest_compl = 0;
    #1;
    checkOutput("compl_next_cycle", p_rs_v[0], 1);

    clearInputs();
    applyStimulus(0, 1, 0, 0, 9, 1, 6'h23, 0);
    complete = 1; regdest_compl = 1; p_rd_compl = 6'h23;
    step();
    clearInputs();
    checkMap("set_wins_map9", 9, 6'h23);
    checkOutput("set_wins_ready", p_rs_v[0], 1);

    applyStimulus(0, 1, 0, 0, 10, 1, 6'h24, 0);
    hazard_stall = 1;
    step();
    clearInputs();
    checkMap("stall_map10", 10, 6'd10);

    applyStimulus(0, 1, 0, 0, 0, 0, 6'h00, 1);
    #1;
    checkOutput("br_a_ckpt_id", ckpt_id, 0);
    step();
    clearInputs();
    applyStimulus(0, 1, 0, 0, 3, 1, 6'h30, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 6'h00, 1);
    #1;
    checkOutput("br_b_ckpt_id", ckpt_id, 1);
    step();
    clearInputs();
    checkMap("map3_before_mp", 3, 6'h30);
    br_resolve = 1; br_mispredict = 1; br_ckpt_id = 0;
    applyStimulus(0, 1, 0, 0, 12, 1, 6'h31, 0);
    step();
    clearInputs();
    checkMap("mp_restore_map3", 3, 6'h20);
    checkMap("mp_drop_map12", 12, 6'd12);
    checkOutput("mp_all_free_id", ckpt_id, 0);
    checkOutput("mp_all_free_full", ckpt_full, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 6'h00, 1);
      #1;
      checkOutput($sformatf("alloc_id_%0d", i), ckpt_id, i);
      step();
      clearInputs();
    end
    checkOutput("four_br_full", ckpt_full, 1);
    br_resolve = 1; br_ckpt_id = 1;
    #1;
    checkOutput("resolve_full_pre", ckpt_full, 1);
    step();
    clearInputs();
    #1;
    checkOutput("resolve_full_post", ckpt_full, 0);
    checkOutput("resolve_free_id", ckpt_id, 1);

    applyStimulus(0, 1, 0, 0, 0, 0, 6'h00, 1);
    step();
    clearInputs();
    checkOutput("realloc_full", ckpt_full, 1);
    br_resolve = 1; br_mispredict = 1; br_ckpt_id = 2;
    step();
    clearInputs();
    #1;
    checkOutput("age_mp_full", ckpt_full, 0);
    checkOutput("age_mp_id", ckpt_id, 1);
    checkMap("age_mp_map3", 3, 6'h20);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 6'h00, 1);
      #1;
      checkOutput($sformatf("age_alloc_id_%0d", i), ckpt_id, i);
      step();
      clearInputs();
    end
    checkOutput("age_keep_full", ckpt_full, 1);

    applyStimulus(0, 1, 0, 0, 0, 0, 6'h00, 1);
    applyStimulus(1, 1, 0, 0, 13, 1, 6'h32, 0);
    step();
    clearInputs();
    checkMap("full_br_map13", 13, 6'd13);
    checkOutput("full_br_still_full", ckpt_full, 1);

    applyStimulus(0, 1, 0, 0, 6, 1, 6'h34, 0);
    step();
    clearInputs();
    checkMap("pre_rec_map6", 6, 6'h34);
    recover = 1; recover_rd = 6; p_rd_flush = 6'd6; regdest_rob = 1;
    applyStimulus(0, 1, 0, 0, 6, 1, 6'h33, 0);
    applyStimulus(1, 1, 0, 0, 14, 1, 6'h35, 0);
    step();
    clearInputs();
    checkMap("rec_map6", 6, 6'd6);
    checkMap("rec_drop_map14", 14, 6'd14);
    recover = 1; recover_rd = 6; p_rd_flush = 6'h3f; regdest_rob = 0;
    applyStimulus(1, 1, 0, 0, 15, 1, 6'h36, 0);
    step();
    clearInputs();
    checkMap("rec_noreg_map6", 6, 6'd6);
    checkMap("rec_noreg_map15", 15, 6'd15);

    br_resolve = 1; br_mispredict = 1; br_ckpt_id = 1;
    rst = 1'b1;
    checkMap("abort_map3", 3, 6'd3);
    checkOutput("abort_full", ckpt_full, 0);
    checkOutput("abort_ckpt_id", ckpt_id, 0);
    clearInputs();
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_map_ckpt.md
RENAME_MAP_CKPT -- requirements
Module: rename_map_ckpt

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  NUM_LREG, 32, logical registers; LW = clog2(NUM_LREG).
  NUM_PREG, 64, physical registers; PW = clog2(NUM_PREG).
  DW, 2, dispatch width (slots per cycle).
  NUM_CKPT, 4, branch checkpoints; CW = clog2(NUM_CKPT).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk, in, 1, clock.
  rst, in, 1, reset; asynchronous, active-high.
  hazard_stall, in, 1, blocks all dispatch state updates.
  disp_valid, in, DW, per-slot dispatch valid.
  l_rs / l_rt / l_rd, in, DW*LW, logical sources and destination, slot k at [k*LW +: LW].
  reg_dest, in, DW, slot writes l_rd.
  p_rd_new, in, DW*PW, allocated physical destination.
  is_branch, in, DW, slot is a branch; at most one per group.
  p_rs / p_rt, out, DW*PW, renamed sources (combinational).
  p_rs_v / p_rt_v, out, DW, source ready.
  pr_old_rd, out, DW*PW, previous mapping of l_rd, for the ROB.
  ckpt_full, out, 1, no free checkpoint.
  ckpt_id, out, CW, checkpoint allocated to this group's branch.
  br_resolve, in, 1, a branch resolved.
  br_mispredict, in, 1, resolution was a mispredict.
  br_ckpt_id, in, CW, checkpoint of the resolving branch.
  recover, in, 1, ROB-walk undo of one entry.
  recover_rd, in, LW, logical register to restore.
  p_rd_flush, in, PW, physical register to restore.
  regdest_rob, in, 1, ROB entry wrote a register.
  complete, in, 1, CDB completion.
  p_rd_compl, in, PW, completing register.
  regdest_compl, in, 1, completion writes a register.

Function
REQ-003 SHALL keep map[NUM_LREG] of PW bits and ready[NUM_PREG] of 1 bit.
REQ-004 SHALL perform lookup combinationally from the map, with intra-group bypass:
  - slot k source matching l_rd of an earlier valid reg_dest slot j<k takes the youngest such p_rd_new[j], ready=0.
REQ-005 SHALL drive pr_old_rd[k] as the map value, or the youngest earlier same-group p_rd_new on a WAW match.
REQ-006 SHALL on a clock edge with disp_valid[k] & reg_dest[k] & !hazard_stall & !recover & !br_mispredict:
  - write map[l_rd[k]] = p_rd_new[k]; youngest slot wins a WAW;
  - clear ready[p_rd_new[k]].
REQ-007 SHALL on a branch-slot dispatch, if !ckpt_full:
  - snapshot the map including same-group writes from slots <= the branch slot;
  - mark the lowest free checkpoint busy and present its index on ckpt_id the same cycle.
REQ-008 SHALL leave the snapshot taken and map unchanged if a branch dispatches while ckpt_full; upstream stalls on ckpt_full.
REQ-009 SHALL on complete & regdest_compl set ready[p_rd_compl] at the next edge, including during recover; the set wins over a same-edge clear of that register.
REQ-010 SHALL on br_resolve & !br_mispredict free checkpoint br_ckpt_id.
REQ-011 SHALL on br_resolve & br_mispredict, with one-cycle latency:
  - copy checkpoint br_ckpt_id into map;
  - free that checkpoint and all checkpoints allocated after it (age tracked per checkpoint);
  - drop same-edge dispatch.
REQ-012 SHALL on recover & regdest_rob write map[recover_rd] = p_rd_flush; dispatch is dropped while recover=1; recover & !regdest_rob changes nothing.
REQ-013 SHALL apply priority mispredict restore > recover > dispatch; simultaneous restore and resolve of a different checkpoint still frees the correctly resolved one.
REQ-014 SHALL assert ckpt_full combinationally when all checkpoints are busy.

Reset
REQ-015 SHALL on rst asynchronously set map[i]=i, ready all 1, all checkpoints free, ckpt_full=0, ckpt_id=0.
REQ-016 SHALL treat rst mid-restore or mid-walk as an abort: state equals the REQ-015 values.

Configuration
REQ-017 SHALL, with MAPT_READY_BYPASS_EN defined, force p_rs_v/p_rt_v to 1 when the source equals p_rd_compl with complete & regdest_compl in the same cycle; without it, ready is visible one cycle after the completion.

Structure
REQ-018 SHALL place NUM_LREG, NUM_PREG, DW, NUM_CKPT defaults and the checkpoint-age type in shared package ooo_pkg.
REQ-019 SHALL implement checkpoint storage, allocation and age-based free in sub-module map_ckpt_store.

Verification
REQ-020 Reset, then lookup l_rs=5 -> p_rs=5, p_rs_v=1.
REQ-021 Slot0 r3->0x20, slot1 rs=r3 same group -> p_rs[1]=0x20, p_rs_v[1]=0; slot0 and slot1 both rd=r7 (0x21, 0x22) -> map[7]=0x22, pr_old_rd[1]=0x21.
REQ-022 Complete 0x20 with regdest_compl=1 -> next cycle ready[0x20]=1; with regdest_compl=0 -> stays 0; with macro, same-cycle p_rs_v=1.
REQ-023 Branch checkpoint after r3->0x20, then r3->0x30, mispredict on that ckpt_id -> next cycle map[3]=0x20 and younger checkpoints freed.
REQ-024 Four branches without resolve -> ckpt_full=1; one correct resolve -> ckpt_full=0.
REQ-025 recover=1, recover_rd=6, p_rd_flush=6, regdest_rob=1, with a concurrent dispatch -> map[6]=6, dispatch write absent.
